// File: rtl/minmax_tracker_pkg.sv
// minmax_tracker_pkg: state encoding and default sizes shared by the min/max tracker
package minmax_tracker_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;
endpackage

// File: rtl/minmax_tracker_cmp.sv
// minmax_tracker_cmp: unsigned magnitude comparator
// Ports: A, B (WIDTH operands); A_gt_B, A_eq_B, A_lt_B (one-hot relation of A to B)
module minmax_tracker_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             A_gt_B,
  output logic             A_eq_B,
  output logic             A_lt_B
);
  assign A_gt_B = A > B;
  assign A_eq_B = A == B;
  assign A_lt_B = A < B;
endmodule

// File: rtl/minmax_tracker.sv
// minmax_tracker: per-frame max/min with first-occurrence indices and sample count
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_data/in_last sample stream;
//        out_valid/out_ready handshake with out_max, out_min, out_max_idx, out_min_idx,
//        out_count, out_sat frame result
module minmax_tracker
  import minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_max_idx,
  output logic [CNT_W-1:0] out_min_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat
);
  state_t state, state_n;
  logic [WIDTH-1:0] max_q, min_q;
  logic [CNT_W-1:0] max_idx_q, min_idx_q, count_q;
  logic sat_q, gt, lt, take, full;
  minmax_tracker_cmp #(.WIDTH(WIDTH)) u_max_cmp (
    .A(in_data), .B(max_q), .A_gt_B(gt), .A_eq_B(), .A_lt_B()
  );
  minmax_tracker_cmp #(.WIDTH(WIDTH)) u_min_cmp (
    .A(in_data), .B(min_q), .A_gt_B(), .A_eq_B(), .A_lt_B(lt)
  );
  assign in_ready    = state != HOLD;
  assign take        = in_valid && in_ready;
  // the counter doubles as the index of the incoming sample, so both saturate together
  assign full        = &count_q;
  assign out_valid   = state == HOLD;
  assign out_max     = max_q;
  assign out_min     = min_q;
  assign out_max_idx = max_idx_q;
  assign out_min_idx = min_idx_q;
  assign out_count   = count_q;
  assign out_sat     = sat_q;
  always_comb begin
    state_n = state;
    state_n = (state == HOLD) ? (out_ready ? IDLE : HOLD) : take ? (in_last ? HOLD : ACCUM) : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      max_q     <= '0;
      min_q     <= '0;
      max_idx_q <= '0;
      min_idx_q <= '0;
      count_q   <= '0;
      sat_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (take && state == IDLE) begin
        max_q     <= in_data;
        min_q     <= in_data;
        max_idx_q <= '0;
        min_idx_q <= '0;
        count_q   <= CNT_W'(1);
        sat_q     <= 1'b0;
      end else if (take) begin
        if (gt) begin
          max_q     <= in_data;
          max_idx_q <= count_q;
        end
        if (lt) begin
          min_q     <= in_data;
          min_idx_q <= count_q;
        end
        count_q <= full ? count_q : count_q + 1'b1;
        sat_q   <= sat_q | full;
      end
    end
  end
endmodule

// File: tb/tb_minmax_tracker.sv
// tb_minmax_tracker: directed checks of frame extremes, ties, backpressure, saturation and reset
module tb_minmax_tracker;
  logic clk = 1'b0;
  logic rst, in_valid, in_last, out_ready, in_ready, out_valid, out_sat;
  logic [3:0] in_data, out_max, out_min;
  logic [7:0] out_max_idx, out_min_idx, out_count;
  logic v2, l2, r2, rdy2, ov2, sat2;
  logic [3:0] d2, max2, min2;
  logic [1:0] maxi2, mini2, cnt2;
  int total = 0;
  int pass = 0;
  always #5 clk = ~clk;
  minmax_tracker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_min(out_min), .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
    .out_count(out_count), .out_sat(out_sat)
  );
  minmax_tracker #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .in_data(d2),
    .in_last(l2), .out_valid(ov2), .out_ready(r2), .out_max(max2),
    .out_min(min2), .out_max_idx(maxi2), .out_min_idx(mini2),
    .out_count(cnt2), .out_sat(sat2)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask
  task automatic send(input logic [3:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
  endtask
  task automatic send2(input logic [3:0] d, input logic l);
    v2 = 1'b1;
    d2 = d;
    l2 = l;
    step();
  endtask
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    v2 = 1'b0; d2 = '0; l2 = 1'b0; r2 = 1'b0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_max", out_max, 0);
    chk("rst_count", out_count, 0);
    chk("rst_sat", out_sat, 0);
    rst = 1'b0;
    out_ready = 1'b1;
    send(3, 0);
    send(1, 0);
    send(10, 0);
    chk("f1_mid_valid", out_valid, 0);
    send(5, 1);
    in_valid = 1'b0;
    chk("f1_valid", out_valid, 1);
    chk("f1_in_ready", in_ready, 0);
    chk("f1_max", out_max, 10);
    chk("f1_max_idx", out_max_idx, 2);
    chk("f1_min", out_min, 1);
    chk("f1_min_idx", out_min_idx, 1);
    chk("f1_count", out_count, 4);
    chk("f1_sat", out_sat, 0);
    step();
    chk("f1_valid_drop", out_valid, 0);
    chk("f1_ready_back", in_ready, 1);
    send(7, 1);
    chk("f2_valid", out_valid, 1);
    chk("f2_max", out_max, 7);
    chk("f2_min", out_min, 7);
    chk("f2_max_idx", out_max_idx, 0);
    chk("f2_min_idx", out_min_idx, 0);
    chk("f2_count", out_count, 1);
    in_data = 6;
    step();
    chk("f2_xfer_valid", out_valid, 0);
    chk("f2_xfer_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("f2_next_valid", out_valid, 1);
    chk("f2_next_max", out_max, 6);
    chk("f2_next_count", out_count, 1);
    step();
    send(5, 0);
    send(9, 0);
    send(9, 0);
    send(2, 0);
    out_ready = 1'b0;
    send(2, 1);
    in_data = 4;
    chk("tie_valid", out_valid, 1);
    chk("tie_max", out_max, 9);
    chk("tie_max_idx", out_max_idx, 1);
    chk("tie_min", out_min, 2);
    chk("tie_min_idx", out_min_idx, 3);
    chk("tie_count", out_count, 5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_max", out_max, 9);
      chk("bp_min_idx", out_min_idx, 3);
      chk("bp_count", out_count, 5);
    end
    out_ready = 1'b1;
    step();
    chk("bp_xfer_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("bp_acc_valid", out_valid, 1);
    chk("bp_acc_max", out_max, 4);
    chk("bp_acc_count", out_count, 1);
    step();
    send(8, 0);
    send(6, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    chk("mr_valid", out_valid, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_max", out_max, 0);
    rst = 1'b0;
    step();
    chk("mr_post_valid", out_valid, 0);
    send(2, 0);
    chk("mr_mid_valid", out_valid, 0);
    send(3, 1);
    in_valid = 1'b0;
    chk("mr_valid_res", out_valid, 1);
    chk("mr_max_res", out_max, 3);
    chk("mr_max_idx", out_max_idx, 1);
    chk("mr_min_res", out_min, 2);
    chk("mr_min_idx", out_min_idx, 0);
    chk("mr_count", out_count, 2);
    step();
    r2 = 1'b1;
    send2(1, 0);
    send2(2, 0);
    send2(3, 0);
    send2(4, 0);
    chk("sat_mid_count", cnt2, 3);
    send2(0, 1);
    v2 = 1'b0;
    chk("sat_valid", ov2, 1);
    chk("sat_count", cnt2, 3);
    chk("sat_flag", sat2, 1);
    chk("sat_max", max2, 4);
    chk("sat_max_idx", maxi2, 3);
    chk("sat_min", min2, 0);
    chk("sat_min_idx", mini2, 3);
    step();
    chk("sat_xfer_valid", ov2, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/minmax_tracker.md
Name: minmax_tracker

Overview:
Streaming stage directly downstream of the team's parameterised magnitude comparator. Accepts a stream of unsigned samples grouped into frames and compares each sample against the running maximum and the running minimum. It uses two instances of the comparator for this. At frame end it presents max, min, their first-occurrence indices, and the sample count on a valid/ready output. Used wherever a block needs per-frame extremes, e.g. peak detection or range checks.

Parameters:
WIDTH, 4, sample width in bits; unsigned; passed to both comparator instances.
CNT_W, 8, width of the sample counter and the index outputs.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  sample present on in_data.
in_ready  output  1  block can accept a sample this cycle.
in_data  input  WIDTH  unsigned sample.
in_last  input  1  marks the final sample of a frame; qualified by in_valid.
out_valid  output  1  frame result valid.
out_ready  input  1  consumer accepts the result.
out_max  output  WIDTH  largest sample in the frame.
out_min  output  WIDTH  smallest sample in the frame.
out_max_idx  output  CNT_W  0-based index of the first occurrence of the max.
out_min_idx  output  CNT_W  0-based index of the first occurrence of the min.
out_count  output  CNT_W  number of samples in the frame (saturating).
out_sat  output  1  the frame exceeded 2^CNT_W-1 samples.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high. While rst=1 at a rising edge: state=IDLE and all outputs 0, except in_ready=1 from the first cycle after reset.
- Handshake:
  - Input transfer happens when in_valid && in_ready at the rising edge.
  - Output transfer happens when out_valid && out_ready.
  - in_ready = (state != HOLD); it is registered-state based, with no combinational path from out_ready.
- State IDLE (no sample yet in frame), on an accepted sample:
  - max=min=in_data; max_idx=min_idx=0; count=1; sat=0.
  - Go to HOLD if in_last, else ACCUM.
- State ACCUM, on an accepted sample, with idx = current count:
  - Strictly greater than max: max=in_data, max_idx=idx.
  - Strictly less than min: min=in_data, min_idx=idx.
  - Equality updates neither (first occurrence wins).
  - count increments. At 2^CNT_W-1 it holds and sets sat=1; idx saturates identically.
  - Go to HOLD if in_last.
- State HOLD:
  - out_valid=1; all out_* are stable and equal to the frame registers.
  - in_ready=0; in_valid is ignored.
  - On out_ready, go to IDLE.
  - out_valid drops the cycle after the transfer; out_* hold their last values until the next result (not checked).
- Latency:
  - out_valid rises the cycle after the in_last sample is accepted.
  - A new frame's first sample can be accepted the cycle after the output transfer. Minimum frame-to-frame gap is one bubble cycle.
- No accepted sample means no state change. in_data and in_last are don't-care while in_valid=0.
- Reset mid-frame or in HOLD: the partial or pending result is discarded, with no output transfer.
- All comparisons are unsigned WIDTH-bit. Values are never widened or truncated.

Decomposition:
- Shared package holds the state encoding (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2) and the default WIDTH/CNT_W constants.
- Sub-module is the existing comparator, instantiated twice, with unused outputs left unconnected:
  - (in_data vs max) using A_gt_B.
  - (in_data vs min) using A_lt_B.
- The remaining logic (FSM, registers, counter) lives in minmax_tracker itself.

Test Plan:
- Frame 3,1,10,5 with last on 5 and out_ready=1 -> one cycle later out_valid=1, max=10 idx2, min=1 idx1, count=4, sat=0.
- Single-sample frame 7 with last -> max=min=7, both idx0, count=1. The next frame's sample is accepted the cycle after the output transfer.
- Ties 5,9,9,2,2 (last on the final 2) -> max=9 idx1, min=2 idx3, count=5.
- Backpressure: out_ready=0 for 3 cycles after the result, with in_valid=1 and data 4 held -> in_ready=0 and out_* unchanged throughout. Sample 4 is accepted the cycle after out_ready=1.
- CNT_W=2, a 5-sample frame 1,2,3,4,0 -> count=3, sat=1, max=4 idx3 (saturated), min=0 idx3, while max is still correct.
- rst=1 pulsed after samples 8,6 of an unfinished frame, then frame 2,3 (last) -> result max=3 idx1, min=2 idx0, count=2. No stale 8 or 6 appears, and out_valid stays 0 during and after reset until the new last.
